// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline redirect controller.
//   state_e     : controller FSM states
//   src_e       : redirect source, numeric value doubles as priority (higher wins)
//   Flush*      : per-source flush masks, bit order {ex, id, if}
//   flush_mask(): source -> flush mask
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPend  = 2'd1,
    StDrain = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SrcNone   = 2'd0,
    SrcJump   = 2'd1,
    SrcBranch = 2'd2,
    SrcTrap   = 2'd3
  } src_e;

  localparam logic [2:0] FlushNone   = 3'b000;
  localparam logic [2:0] FlushJump   = 3'b001;
  localparam logic [2:0] FlushBranch = 3'b011;
  localparam logic [2:0] FlushTrap   = 3'b111;

  // Drain counter width; FLUSH_CYCLES is limited to 15.
  localparam int unsigned CntW = 4;

  function automatic logic [2:0] flush_mask(src_e src);
    logic [2:0] mask;
    unique case (src)
      SrcTrap:   mask = FlushTrap;
      SrcBranch: mask = FlushBranch;
      SrcJump:   mask = FlushJump;
      default:   mask = FlushNone;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pipeline_redirect_ctrl_if.sv
// Redirect bus between the request sources, the controller and the fetch stage.
//   Requests : trap_req/trap_pc, ex_branch_taken/ex_branch_pc, id_jump_req/id_jump_pc
//   Fetch    : redir_valid/redir_ready/redir_pc handshake, fetch_stall
//   Flushes  : if_flush, id_flush, ex_flush (single-cycle pulses)
// Modports: slave = controller, master = request/fetch side (or testbench).
interface pipeline_redirect_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            trap_req;
  logic [XLEN-1:0] trap_pc;
  logic            ex_branch_taken;
  logic [XLEN-1:0] ex_branch_pc;
  logic            id_jump_req;
  logic [XLEN-1:0] id_jump_pc;
  logic            redir_ready;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            if_flush;
  logic            id_flush;
  logic            ex_flush;
  logic            fetch_stall;

  modport slave (
    input  trap_req, trap_pc, ex_branch_taken, ex_branch_pc, id_jump_req, id_jump_pc,
    input  redir_ready,
    output redir_valid, redir_pc, if_flush, id_flush, ex_flush, fetch_stall
  );

  modport master (
    output trap_req, trap_pc, ex_branch_taken, ex_branch_pc, id_jump_req, id_jump_pc,
    output redir_ready,
    input  redir_valid, redir_pc, if_flush, id_flush, ex_flush, fetch_stall
  );

endinterface

// File: rtl/redirect_prio_sel.sv
// Combinational fixed-priority selector for redirect requests.
//   trap_req_i/trap_pc_i     : priority 3 (highest)
//   branch_req_i/branch_pc_i : priority 2
//   jump_req_i/jump_pc_i     : priority 1
//   src_o/pc_o               : winning source (SrcNone if idle) and its target
module redirect_prio_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            branch_req_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            jump_req_i,
  input  logic [XLEN-1:0] jump_pc_i,
  output src_e            src_o,
  output logic [XLEN-1:0] pc_o
);

  always_comb begin
    src_o = SrcNone;
    pc_o  = '0;
    if (trap_req_i) begin
      src_o = SrcTrap;
      pc_o  = trap_pc_i;
    end else if (branch_req_i) begin
      src_o = SrcBranch;
      pc_o  = branch_pc_i;
    end else if (jump_req_i) begin
      src_o = SrcJump;
      pc_o  = jump_pc_i;
    end
  end

endmodule

// File: rtl/pipeline_redirect_ctrl.sv
// Pipeline redirect controller: arbitrates trap / EX branch / ID jump redirects, presents one
// redirect PC to fetch over valid/ready, pulses per-stage flushes and stalls fetch for a
// drain window after each completed handshake.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : pipeline_redirect_ctrl_if.slave (requests, fetch handshake, flushes, stall)
// Parameters: XLEN (PC width), FLUSH_CYCLES (drain length, 0..15), STAT_W (stats width).
// Optional: define REDIRECT_STATS_EN to add saturating counters
//   stat_redirects_o (completed handshakes) and stat_preempts_o (preemptions while pending).
module pipeline_redirect_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STAT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef REDIRECT_STATS_EN
  output logic [STAT_W-1:0]       stat_redirects_o,
  output logic [STAT_W-1:0]       stat_preempts_o,
`endif
  pipeline_redirect_ctrl_if.slave bus
);

  localparam logic [CntW-1:0] DrainLoad = CntW'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        flush_q, flush_d;

  src_e              win_src;
  logic [XLEN-1:0]   win_pc;
  logic              hi_req;
  logic              accept;

  redirect_prio_sel #(
    .XLEN (XLEN)
  ) u_prio_sel (
    .trap_req_i   (bus.trap_req),
    .trap_pc_i    (bus.trap_pc),
    .branch_req_i (bus.ex_branch_taken),
    .branch_pc_i  (bus.ex_branch_pc),
    .jump_req_i   (bus.id_jump_req),
    .jump_pc_i    (bus.id_jump_pc),
    .src_o        (win_src),
    .pc_o         (win_pc)
  );

  // Trap or branch present; these may cut a handshake or drain short, a jump may not.
  assign hi_req = (win_src == SrcTrap) || (win_src == SrcBranch);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= SrcNone;
      pc_q    <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = FlushNone;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = (win_src != SrcNone);
      end
      StPend: begin
        if (bus.redir_ready) begin
          // Handshake completes; a concurrent trap/branch becomes the next redirect.
          if (hi_req) begin
            accept = 1'b1;
          end else if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
            src_d   = SrcNone;
          end else begin
            state_d = StDrain;
            src_d   = SrcNone;
            cnt_d   = DrainLoad;
          end
        end else if (win_src > src_q) begin
          accept = 1'b1;
        end
      end
      StDrain: begin
        if (hi_req) begin
          accept = 1'b1;
        end else if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        src_d   = SrcNone;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      state_d = StPend;
      src_d   = win_src;
      pc_d    = win_pc;
      cnt_d   = '0;
      flush_d = flush_mask(win_src);
    end
  end

  // Outputs, all decoded from registered state
  always_comb begin
    bus.redir_valid = (state_q == StPend);
    bus.fetch_stall = (state_q == StDrain);
    bus.redir_pc    = pc_q;
    bus.if_flush    = flush_q[0];
    bus.id_flush    = flush_q[1];
    bus.ex_flush    = flush_q[2];
  end

`ifdef REDIRECT_STATS_EN
  logic              hs_evt, pre_evt;
  logic [STAT_W-1:0] stat_red_q, stat_red_d;
  logic [STAT_W-1:0] stat_pre_q, stat_pre_d;

  assign hs_evt  = (state_q == StPend) && bus.redir_ready;
  assign pre_evt = (state_q == StPend) && !bus.redir_ready && (win_src > src_q);

  always_comb begin
    stat_red_d = stat_red_q;
    stat_pre_d = stat_pre_q;
    if (hs_evt && (stat_red_q != '1)) stat_red_d = stat_red_q + 1'b1;
    if (pre_evt && (stat_pre_q != '1)) stat_pre_d = stat_pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_red_q <= '0;
      stat_pre_q <= '0;
    end else begin
      stat_red_q <= stat_red_d;
      stat_pre_q <= stat_pre_d;
    end
  end

  assign stat_redirects_o = stat_red_q;
  assign stat_preempts_o  = stat_pre_q;
`endif

endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
// Self-checking bench for pipeline_redirect_ctrl: directed vector table, async-reset sequence,
// randomized traffic against a behavioural model, and stats checks when REDIRECT_STATS_EN is set.
module tb_pipeline_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLUSH = 2;
  localparam int unsigned SW    = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

`ifdef REDIRECT_STATS_EN
  logic [SW-1:0] stat_redirects;
  logic [SW-1:0] stat_preempts;
`endif

  pipeline_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  pipeline_redirect_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FLUSH),
    .STAT_W       (SW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef REDIRECT_STATS_EN
    .stat_redirects_o (stat_redirects),
    .stat_preempts_o  (stat_preempts),
`endif
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trap;
    logic [31:0] trap_pc;
    logic        br;
    logic [31:0] br_pc;
    logic        jmp;
    logic [31:0] jmp_pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_flush;  // {ex, id, if}
    logic        exp_stall;
  } vec_t;

  vec_t vecs[20];

  // Behavioural model: pending flag + priority, remaining stall cycles, last target.
  bit          m_pend;
  int          m_prio;
  logic [31:0] m_pc;
  int          m_drain;
  logic [2:0]  m_flush;

  task automatic model_reset();
    m_pend  = 1'b0;
    m_prio  = 0;
    m_pc    = 32'h0;
    m_drain = 0;
    m_flush = 3'b000;
  endtask

  task automatic model_step(input logic t, input logic [31:0] tp, input logic b,
                            input logic [31:0] bp, input logic j, input logic [31:0] jp,
                            input logic r);
    int          prio;
    logic [31:0] tgt;
    bit          take;
    prio = t ? 3 : (b ? 2 : (j ? 1 : 0));
    tgt  = t ? tp : (b ? bp : jp);
    take = 1'b0;
    if (m_pend) begin
      if (r) begin
        if (prio >= 2) take = 1'b1;
        else begin
          m_pend  = 1'b0;
          m_drain = FLUSH;
        end
      end else if (prio > m_prio) begin
        take = 1'b1;
      end
    end else if (m_drain > 0) begin
      if (prio >= 2) take = 1'b1;
      else m_drain--;
    end else begin
      take = (prio > 0);
    end
    m_flush = take ? {prio == 3, prio >= 2, 1'b1} : 3'b000;
    if (take) begin
      m_pend  = 1'b1;
      m_prio  = prio;
      m_pc    = tgt;
      m_drain = 0;
    end
  endtask

  task automatic drive(input logic t, input logic [31:0] tp, input logic b,
                       input logic [31:0] bp, input logic j, input logic [31:0] jp,
                       input logic r);
    bus.trap_req        = t;
    bus.trap_pc         = tp;
    bus.ex_branch_taken = b;
    bus.ex_branch_pc    = bp;
    bus.id_jump_req     = j;
    bus.id_jump_pc      = jp;
    bus.redir_ready     = r;
  endtask

  task automatic drive_idle(input logic r);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, r);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [31:0] epc,
                       input logic [2:0] efl, input logic es);
    logic [2:0] afl;
    afl = {bus.ex_flush, bus.id_flush, bus.if_flush};
    n_checks++;
    if (bus.redir_valid !== ev || bus.redir_pc !== epc || afl !== efl ||
        bus.fetch_stall !== es) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b pc=%h flush=%b stall=%0b, want valid=%0b pc=%h flush=%b stall=%0b",
               name, bus.redir_valid, bus.redir_pc, afl, bus.fetch_stall, ev, epc, efl, es);
    end
  endtask

  task automatic reset_dut();
    drive_idle(1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        t, b, j, r;
    logic [31:0] tp, bp, jp;
    n_checks = 0;
    n_fail   = 0;

    //          trap  tpc       br    bpc        jmp   jpc        rdy   valid pc        flush   stall
    vecs[0]  = '{1'b0, 32'h0,   1'b1, 32'h100,  1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 3'b011, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 3'b000, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 3'b000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 3'b000, 1'b0};
    vecs[4]  = '{1'b1, 32'h8,   1'b1, 32'h200,  1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   3'b111, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   3'b000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 32'h300,  1'b1, 32'h400, 1'b0, 1'b1, 32'h8,   3'b000, 1'b0};
    vecs[7]  = '{1'b1, 32'hC,   1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   3'b111, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   3'b000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h500, 1'b0, 1'b0, 32'hC,   3'b000, 1'b1};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 32'hC,   3'b000, 1'b0};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h40,  1'b0, 1'b1, 32'h40,  3'b001, 1'b0};
    vecs[12] = '{1'b0, 32'h0,   1'b1, 32'h80,   1'b0, 32'h0,   1'b0, 1'b1, 32'h80,  3'b011, 1'b0};
    vecs[13] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h90,  1'b0, 1'b1, 32'h80,  3'b000, 1'b0};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h44,  1'b1, 1'b0, 32'h80,  3'b000, 1'b1};
    vecs[15] = '{1'b0, 32'h0,   1'b1, 32'h600,  1'b0, 32'h0,   1'b0, 1'b1, 32'h600, 3'b011, 1'b0};
    vecs[16] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'h600, 3'b000, 1'b1};
    vecs[17] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'h600, 3'b000, 1'b1};
    vecs[18] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 32'h600, 3'b000, 1'b0};
    vecs[19] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'h600, 3'b000, 1'b0};

    rst_n = 1'b1;
    reset_dut();
    check("reset", 1'b0, 32'h0, 3'b000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].trap, vecs[i].trap_pc, vecs[i].br, vecs[i].br_pc,
            vecs[i].jmp, vecs[i].jmp_pc, vecs[i].ready);
      cycle();
      check($sformatf("vec[%0d]", i), vecs[i].exp_valid, vecs[i].exp_pc,
            vecs[i].exp_flush, vecs[i].exp_stall);
    end

    // Asynchronous reset while a redirect is pending and fetch is not ready.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h70, 1'b0);
    cycle();
    check("pend_before_rst", 1'b1, 32'h70, 3'b001, 1'b0);
    drive_idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1'b0, 32'h0, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("post_rst[%0d]", i), 1'b0, 32'h0, 3'b000, 1'b0);
    end

    // Randomized traffic against the model.
    reset_dut();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      t  = ($urandom_range(9) == 0);
      b  = ($urandom_range(4) == 0);
      j  = ($urandom_range(3) == 0);
      r  = ($urandom_range(1) == 0);
      tp = $urandom;
      bp = $urandom;
      jp = $urandom;
      drive(t, tp, b, bp, j, jp, r);
      model_step(t, tp, b, bp, j, jp, r);
      cycle();
      check($sformatf("rand[%0d]", c), m_pend, m_pc, m_flush, m_drain > 0);
    end

`ifdef REDIRECT_STATS_EN
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
      cycle();
      drive_idle(1'b1);
      repeat (4) cycle();
    end
    n_checks++;
    if (stat_redirects !== 2'd3) begin
      n_fail++;
      $display("FAIL stat_redirects: got %0d want 3", stat_redirects);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
    cycle();
    drive_idle(1'b0);
    cycle();
    n_checks++;
    if (stat_preempts !== 2'd1) begin
      n_fail++;
      $display("FAIL stat_preempts: got %0d want 1", stat_preempts);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
